store_buffer_unit: RTL
======================

# store_buffer_unit

Parametrised posted-store unit for the load/store path. Store requests are accepted in one cycle, aligned onto byte lanes and queued in a `DEPTH`-entry FIFO. The queue drains in order to a Wishbone master port, with sticky bus-error reporting and an address-hazard check the load path uses to stall loads that overlap a pending store. It replaces the single-transaction blocking store unit.

## Interface
Parameters:
- `DEPTH`, 4: store-buffer entries; power of two, at least 2.
- `DATA_W`, 32: bus data width; 32 or 64. `SEL_W = DATA_W/8`, `OFF_W = log2(SEL_W)`.
- `ADDR_W`, 32: address width.

Ports:
- `clk`, in, 1: clock.
- `rstn_i`, in, 1: reset. One clock; reset is asynchronous and active-low.
- `req_valid_i`, in, 1: store request valid.
- `req_ready_o`, out, 1: buffer can accept a request.
- `addr_i`, in, `ADDR_W`: byte address.
- `data_i`, in, `DATA_W`: store data, right-aligned (LSB = first byte).
- `size_i`, in, 2: 0 = byte, 1 = half, 2 = word, 3 = dword (legal only if `DATA_W` = 64).
- `misaligned_o`, out, 1: one-cycle pulse; the request was rejected.
- `chk_addr_i`, in, `ADDR_W`: load address for the hazard check.
- `hit_o`, out, 1: combinational; a pending entry shares the `DATA_W`-aligned word of `chk_addr_i`.
- `empty_o`, out, 1: buffer empty and no bus cycle active (fence/drain indicator).
- `err_o`, out, 1: sticky bus error.
- `err_addr_o`, out, `ADDR_W`: address of the first erroring store.
- `err_clr_i`, in, 1: clears `err_o` and `err_addr_o`.
- `wb_bus`, `wb_master_bus_t`: Wishbone master port.

## Operation
- **Accept rule.** A request is accepted when `req_valid_i & req_ready_o`. `req_ready_o = !full`.
- **Alignment check.** A request is misaligned when `addr_i[OFF_W-1:0]` is not a multiple of `2^size_i`, or when `size_i` is illegal for `DATA_W`.
  - A misaligned request is not enqueued.
  - `misaligned_o` pulses in the cycle after acceptance.
- **Lane alignment at enqueue.**
  - `sel = ((1<<2^size_i)-1) << off`.
  - `data = replicate(data_i low 2^size_i bytes) << (8*off)`.
  - The stored address is word-aligned (low `OFF_W` bits zero).
  - Each entry holds {addr, data, sel}.
- **Constant bus drives.** `wb_we_o = 1`; `wb_lock_o`, `wb_tgc_o`, `wb_tgd_o`, `wb_tga_o` = 0. `adr`, `dat`, `sel` come from the FIFO head.
- **State machine.**
  - `IDLE`: `cyc = 0`. If the FIFO is non-empty, go to `BUS`.
  - `BUS`: `cyc = 1`. `stb = wb_gnt_i`.
    - On `wb_ack_i` or `wb_err_i` (only counted while `stb`), pop the head.
    - After the pop: stay in `BUS` if entries remain (including one pushed this cycle), otherwise go to `IDLE`.
    - `wb_rty_i` holds the head; `stb` stays asserted until ack or err.
- **Errors.**
  - `wb_err_i` sets `err_o` and latches `err_addr_o` only if `err_o` is clear (first error wins).
  - The store is dropped and draining continues.
  - `err_clr_i` has priority over a new error in the same cycle.
- **Hazard check.** `hit_o` compares `chk_addr_i[ADDR_W-1:OFF_W]` with every valid entry, including the in-flight head.
- **Push and pop together.**
  - A push and a pop in the same cycle are both honoured; the count is unchanged.
  - When full, `req_ready_o = 0` even if a pop occurs that cycle.
- **Pointers.** `log2(DEPTH)`-bit pointers plus a count of width `log2(DEPTH)+1`. Wrap-around is modulo `DEPTH`.

## Timing
- **Reset values.**
  - State `IDLE`, FIFO empty.
  - `req_ready_o = 1`, `empty_o = 1`.
  - `misaligned_o`, `err_o`, `hit_o` = 0; `err_addr_o = 0`.
  - `cyc`, `stb`, `sel` = 0.
- **Latency.** A store accepted at cycle N into an empty buffer gives `cyc = 1` at N+1, and `stb` at N+1 if `wb_gnt_i` is high. Ack at N+1 pops the entry, `cyc` drops at N+2 and `empty_o = 1` at N+2.
- **Back-to-back.** With ack every cycle, one store completes per cycle and `cyc` stays high continuously.
- **`empty_o` and `hit_o`.** `empty_o` is registered-derived: `(count == 0) & (state == IDLE)`. `hit_o` is combinational, with zero latency.
- **Reset mid-operation.** `rstn_i` low clears the FIFO and drops `cyc`/`stb` immediately (asynchronously). In-flight and queued stores are lost.

## Test plan
- **Single write.** Reset, then one word store to 0x100 with data 0xDEADBEEF; slave grants and acks at once. Required: `cyc` at N+1, `sel = 0xF`, `adr = 0x100`, `empty_o = 1` at N+2.
- **Byte and half lanes.** Byte store to 0x103 with data 0xAB gives `sel = 4'b1000`, `dat = 0xABABABAB`. Half store to 0x102 gives `sel = 4'b1100`. Half store to 0x101 gives a `misaligned_o` pulse and no bus cycle.
- **Full buffer.** With `wb_gnt_i = 0`, push 4 stores: `req_ready_o = 0` after the 4th. Then grant with ack every cycle: the 4 stores drain in order on consecutive cycles with `cyc` continuous.
- **Error and retry.**
  - Retry twice then ack on the head: `adr` and `sel` are held stable and only one pop occurs.
  - `wb_err_i` on the store to 0x200 followed by an error on 0x204: `err_o = 1`, `err_addr_o = 0x200`.
  - `err_clr_i` clears both outputs.
- **Hazard and reset.**
  - With 0x300 pending and stalled, `chk_addr_i = 0x302` gives `hit_o = 1`; `chk_addr_i = 0x304` gives `hit_o = 0`.
  - Asserting `rstn_i` low mid-cycle clears `hit_o`, `cyc` and the count immediately.

Source files
------------

// File: rtl/store_buffer_unit.sv
// store_buffer_unit: posted-store queue for the load/store path.
// Stores are lane-aligned at enqueue, held in a DEPTH-entry FIFO and drained
// in order to a Wishbone master port. Bus errors are reported sticky, and a
// word-granular hazard check lets the load path stall on pending stores.
module store_buffer_unit #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
) (
  input  logic                  clk,
  input  logic                  rstn_i,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic [ADDR_W-1:0]     addr_i,
  input  logic [DATA_W-1:0]     data_i,
  input  logic [1:0]            size_i,
  output logic                  misaligned_o,
  input  logic [ADDR_W-1:0]     chk_addr_i,
  output logic                  hit_o,
  output logic                  empty_o,
  output logic                  err_o,
  output logic [ADDR_W-1:0]     err_addr_o,
  input  logic                  err_clr_i,
  output logic                  wb_cyc_o,
  output logic                  wb_stb_o,
  output logic                  wb_we_o,
  output logic [ADDR_W-1:0]     wb_adr_o,
  output logic [DATA_W-1:0]     wb_dat_o,
  output logic [DATA_W/8-1:0]   wb_sel_o,
  output logic                  wb_lock_o,
  output logic                  wb_tgc_o,
  output logic                  wb_tgd_o,
  output logic                  wb_tga_o,
  input  logic                  wb_gnt_i,
  input  logic                  wb_ack_i,
  input  logic                  wb_err_i,
  input  logic                  wb_rty_i
);

  localparam int SEL_W = DATA_W / 8;
  localparam int OFF_W = $clog2(SEL_W);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int TAG_W = ADDR_W - OFF_W;

  typedef enum logic {IDLE, BUS} state_t;

  // Byte-enable mask: 2^size consecutive lanes starting at the byte offset.
  function automatic logic [SEL_W-1:0] lane_sel(input logic [1:0] size,
                                                input logic [OFF_W-1:0] off);
    int nb;
    nb = 1 << size;
    lane_sel = '0;
    for (int b = 0; b < SEL_W; b++) begin
      if (b >= int'(off) && b < int'(off) + nb) lane_sel[b] = 1'b1;
    end
  endfunction

  // Replicate the low 2^size bytes across the bus. For an aligned offset the
  // replicated pattern already carries the operand on its own lanes, so the
  // lane shift is folded into the replication.
  function automatic logic [DATA_W-1:0] lane_data(input logic [DATA_W-1:0] d,
                                                  input logic [1:0] size);
    int nb;
    nb = 1 << size;
    lane_data = '0;
    for (int b = 0; b < SEL_W; b++) begin
      lane_data[8*b +: 8] = d[8*(b % nb) +: 8];
    end
  endfunction

  // A size wider than the bus, or an offset not a multiple of the size.
  function automatic logic is_misaligned(input logic [1:0] size,
                                         input logic [OFF_W-1:0] off);
    logic [OFF_W-1:0] mask;
    if (int'(size) > OFF_W) return 1'b1;
    mask = OFF_W'((1 << size) - 1);
    return (off & mask) != '0;
  endfunction

  logic [TAG_W-1:0]  mem_tag  [DEPTH];
  logic [DATA_W-1:0] mem_data [DEPTH];
  logic [SEL_W-1:0]  mem_sel  [DEPTH];

  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count, cnt_nxt;
  state_t           state_q, state_d;

  logic              full, accept, req_mis, push, pop;
  logic              cyc, stb;
  logic              mis_p1;
  logic              err_q;
  logic [ADDR_W-1:0] err_addr_q;
  logic              unused_chk_lo;

  assign unused_chk_lo = ^chk_addr_i[OFF_W-1:0];

  assign full    = (count == CNT_W'(DEPTH));
  assign accept  = req_valid_i & ~full;
  assign req_mis = is_misaligned(size_i, addr_i[OFF_W-1:0]);
  assign push    = accept & ~req_mis;
  // Retry holds the head; ack/err only count while strobing.
  assign pop     = stb & ~wb_rty_i & (wb_ack_i | wb_err_i);

  always_comb begin
    cnt_nxt = count;
    if (push && !pop)      cnt_nxt = count + 1'b1;
    else if (!push && pop) cnt_nxt = count - 1'b1;
  end

  // Entry storage: payload only, no reset needed.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_tag[wr_ptr]  <= addr_i[ADDR_W-1:OFF_W];
      mem_data[wr_ptr] <= lane_data(data_i, size_i);
      mem_sel[wr_ptr]  <= lane_sel(size_i, addr_i[OFF_W-1:0]);
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk or negedge rstn_i) begin
    if (!rstn_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= cnt_nxt;
    end
  end

  // Bus state register.
  always_ff @(posedge clk or negedge rstn_i) begin
    if (!rstn_i) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Next state: a push into an empty buffer opens the cycle immediately.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (count != '0 || push) state_d = BUS;
      BUS:  if (cnt_nxt == '0)       state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Bus handshake outputs from the state.
  always_comb begin
    cyc = (state_q == BUS);
    stb = cyc & wb_gnt_i;
  end

  // --- stage p1: rejection pulse one cycle after acceptance ---
  always_ff @(posedge clk or negedge rstn_i) begin
    if (!rstn_i) mis_p1 <= 1'b0;
    else         mis_p1 <= accept & req_mis;
  end

  // Sticky error: first error wins, clear beats a new error.
  always_ff @(posedge clk or negedge rstn_i) begin
    if (!rstn_i) begin
      err_q      <= 1'b0;
      err_addr_q <= '0;
    end else if (err_clr_i) begin
      err_q      <= 1'b0;
      err_addr_q <= '0;
    end else if (pop && wb_err_i && !err_q) begin
      err_q      <= 1'b1;
      err_addr_q <= {mem_tag[rd_ptr], {OFF_W{1'b0}}};
    end
  end

  // Hazard check against every occupied entry, head included.
  always_comb begin
    logic [PTR_W-1:0] idx;
    idx   = '0;
    hit_o = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = rd_ptr + PTR_W'(i);
      if (CNT_W'(i) < count && mem_tag[idx] == chk_addr_i[ADDR_W-1:OFF_W])
        hit_o = 1'b1;
    end
  end

  assign req_ready_o  = ~full;
  assign misaligned_o = mis_p1;
  assign empty_o      = (count == '0) && (state_q == IDLE);
  assign err_o        = err_q;
  assign err_addr_o   = err_addr_q;

  assign wb_cyc_o  = cyc;
  assign wb_stb_o  = stb;
  assign wb_we_o   = 1'b1;
  assign wb_adr_o  = cyc ? {mem_tag[rd_ptr], {OFF_W{1'b0}}} : '0;
  assign wb_dat_o  = cyc ? mem_data[rd_ptr] : '0;
  assign wb_sel_o  = cyc ? mem_sel[rd_ptr]  : '0;
  assign wb_lock_o = 1'b0;
  assign wb_tgc_o  = 1'b0;
  assign wb_tgd_o  = 1'b0;
  assign wb_tga_o  = 1'b0;

endmodule
